ed25519_add_modp_fc: RTL

Flow-controlled shell that feeds operand pairs into an ed25519_add_modp instance and buffers its results. Upstream producers use a valid/ready interface. The adder pipeline itself never stalls, so a credit counter bounds the operations in flight and queued, and results drain through an output FIFO with valid/ready. Sits between the sigverify point-arithmetic scheduler and downstream consumers that can backpressure.

---
 rtl/wd_sigverify_pkg.sv | 10 +
 rtl/ed25519_add_modp.sv | 38 +++
 rtl/ed25519_add_modp_fc_fifo.sv | 71 +++++++
 rtl/ed25519_add_modp_fc.sv | 120 ++++++++++++
 4 files changed

// File: rtl/wd_sigverify_pkg.sv
// Shared field constants for the sigverify point-arithmetic blocks.
package wd_sigverify;

    localparam logic [255:0] ED25519_P   = (256'd1 << 255) - 256'd19;
    // Two's complement of p over 256 bits: adding it subtracts p.
    localparam logic [255:0] ED25519_P_N = 256'd0 - ED25519_P;

    localparam int ED25519_ADD_MODP_LAT = 2;

endpackage

// File: rtl/ed25519_add_modp.sv
// Two-stage modular adder over p = 2^255-19 with metadata carried alongside.
// Stage 1 forms the raw sum, stage 2 conditionally subtracts p.
module ed25519_add_modp
    import wd_sigverify::*;
#(
    parameter int W = 255,
    parameter int M = 128
) (
    input  logic         clk,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [M-1:0] m_i,
    output logic [W-1:0] out0,
    output logic [M-1:0] m_o
);

    localparam logic [W:0] P_W1 = ED25519_P[W:0];
    localparam logic [W:0] P_N  = ED25519_P_N[W:0];

    logic [W:0]   sum_q;
    logic [M-1:0] m_q;
    logic [W-1:0] sub_p;
    logic         ge_p;

    assign sub_p = W'(sum_q + P_N);
    assign ge_p  = (sum_q >= P_W1);

    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, which is what makes this a pipeline; the datapath
    // carries no reset because validity is tracked outside.
    always_ff @(posedge clk) begin
        sum_q <= {1'b0, in0} + {1'b0, in1};
        m_q   <= m_i;
        out0  <= ge_p ? sub_p : sum_q[W-1:0];
        m_o   <= m_q;
    end

endmodule

// File: rtl/ed25519_add_modp_fc_fifo.sv
// First-word-fall-through FIFO with registered pointers and an occupancy count.
module ed25519_add_modp_fc_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DW-1:0]              wr_data,
    input  logic                       pop,
    output logic [DW-1:0]              rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          pop_ok;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_ok  = pop && !empty;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count decide what is visible, so stale words are harmless.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (wr && !pop_ok) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!wr && pop_ok) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr && full && !pop_ok));
        end
    end

endmodule

// File: rtl/ed25519_add_modp_fc.sv
// Flow-controlled shell around ed25519_add_modp: credit-gated issue, a valid
// shift register alongside the adder, and an FWFT result FIFO.
module ed25519_add_modp_fc
    import wd_sigverify::*;
#(
    parameter int W = 255,
    parameter int M = 128,
    parameter int L = ED25519_ADD_MODP_LAT,
    parameter int D = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [W-1:0]           i_a,
    input  logic [W-1:0]           i_b,
    input  logic [M-1:0]           i_m,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [W-1:0]           o_sum,
    output logic [M-1:0]           o_m,
    output logic [$clog2(D+1)-1:0] o_level
);

    localparam int           LW  = $clog2(D + 1);
    localparam logic [W-1:0] P_W = ED25519_P[W-1:0];

    if (D < L + 2) begin : g_depth_check
        $error("ed25519_add_modp_fc: D must be at least L+2");
    end

    logic           rst_q;
    logic [LW-1:0]  used_q;
    logic [LW-1:0]  used_next;
    logic           accept;
    logic           pop;
    logic [L-1:0]   vld_sr;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [M-1:0]   add_m_i;
    logic [W-1:0]   add_sum;
    logic [M-1:0]   add_m_o;
    logic           fifo_empty;
    logic           fifo_full;
    logic [LW-1:0]  fifo_count;
    logic [W+M-1:0] fifo_rd;

    // i_ready looks only at registered state, so o_ready never reaches it combinationally.
    assign i_ready = (used_q < LW'(D)) && !rst_q;
    assign accept  = i_valid && i_ready;
    assign pop     = o_valid && o_ready;
    assign o_valid = !fifo_empty;
    assign o_level = used_q;
    assign {o_sum, o_m} = fifo_rd;

    assign add_a   = accept ? i_a : '0;
    assign add_b   = accept ? i_b : '0;
    assign add_m_i = accept ? i_m : '0;

    // NOTE: the default assignment first keeps this purely combinational;
    // any path leaving used_next unassigned would infer a latch.
    always_comb begin
        used_next = used_q;
        if (accept && !pop) begin
            used_next = used_q + LW'(1);
        end else if (!accept && pop) begin
            used_next = used_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            used_q <= '0;
            vld_sr <= '0;
        end else begin
            used_q <= used_next;
            vld_sr <= (vld_sr << 1) | L'(accept);
        end
    end

    ed25519_add_modp #(
        .W (W),
        .M (M)
    ) u_add (
        .clk  (clk),
        .in0  (add_a),
        .in1  (add_b),
        .m_i  (add_m_i),
        .out0 (add_sum),
        .m_o  (add_m_o)
    );

    ed25519_add_modp_fc_fifo #(
        .DW    (W + M),
        .DEPTH (D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (vld_sr[L-1]),
        .wr_data ({add_sum, add_m_o}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Operands at or above p are out of contract; queued results never exceed credits.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (i_a < P_W && i_b < P_W);
        end
        if (!rst) begin
            assert (fifo_count <= used_q);
            assert (!(fifo_full && fifo_count != LW'(D)));
        end
    end

endmodule
